instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), SHALL be the instruction written into IF/ID on bubble or flush.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 STALL  input  1  SHALL be the hazard-unit request to hold PC and IF/ID.
REQ-006 PC_SRC_SEL  input  1  SHALL be the EX-stage taken-branch/jump redirect request.
REQ-007 BRANCH_TARGET  input  32  SHALL be the redirect address, valid when PC_SRC_SEL=1.
REQ-008 IMEM_INSTR  input  32  SHALL be the instruction-memory read data, valid in any cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
REQ-009 IMEM_BUSYWAIT  input  1  SHALL be the instruction-memory not-ready flag.
REQ-010 IMEM_READ  output  1  SHALL be the instruction-memory read request.
REQ-011 IMEM_ADDR  output  32  SHALL be the fetch address, always equal to the PC register.
REQ-012 IF_ID_INSTR  output  32  SHALL be the registered instruction presented to decode/immediate select.
REQ-013 IF_ID_PC  output  32  SHALL be the registered address of IF_ID_INSTR.
REQ-014 IF_ID_PC_PLUS4  output  32  SHALL be IF_ID_PC+4, registered.
REQ-015 IF_ID_VALID  output  1  SHALL be 1 only when IF_ID_INSTR is a real fetched instruction.

Function
REQ-016 States SHALL be FETCH, HELD, DRAIN; IMEM_READ=1 in FETCH and DRAIN, 0 in HELD and while RESET=1.
REQ-017 A fetch SHALL complete on any rising edge with IMEM_READ=1 and IMEM_BUSYWAIT=0 (zero-wait memory gives one instruction per cycle).
REQ-018 Edge priority SHALL be: RESET > PC_SRC_SEL > STALL > fetch completion.
REQ-019 FETCH, completion, STALL=0: IF/ID <= {IMEM_INSTR, PC, PC+4, VALID=1}; PC <= PC+4.
REQ-020 FETCH, no completion, STALL=0: IF/ID <= bubble (NOP_INSTR, VALID=0, PC fields held); PC held.
REQ-021 FETCH, STALL=1, no completion: PC and IF/ID held; IMEM_READ stays 1.
REQ-022 FETCH, STALL=1, completion: instruction and its PC SHALL go into a one-entry hold buffer; PC <= PC+4; state -> HELD; IF/ID held.
REQ-023 HELD, STALL=1: everything held; HELD, STALL=0: IF/ID <= buffer (VALID=1); state -> FETCH.
REQ-024 PC_SRC_SEL=1 in FETCH with completion or IMEM_BUSYWAIT=0, or in HELD: PC <= {BRANCH_TARGET[31:2],2'b00}; IF/ID flushed (NOP_INSTR, VALID=0); buffer discarded; state -> FETCH; STALL ignored.
REQ-025 PC_SRC_SEL=1 in FETCH with IMEM_BUSYWAIT=1: target SHALL be saved in a redirect register; IF/ID flushed; PC held; state -> DRAIN.
REQ-026 DRAIN: IMEM_READ=1 at the old PC until completion; returned data discarded; IF/ID bubble each cycle; on completion PC <= saved target, state -> FETCH.
REQ-027 PC_SRC_SEL=1 in DRAIN SHALL overwrite the saved target; the latest target wins.
REQ-028 PC and PC+4 arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).

Reset
REQ-029 RESET=1 SHALL asynchronously force PC=RESET_PC, state=FETCH, IF_ID_INSTR=NOP_INSTR, IF_ID_PC=0, IF_ID_PC_PLUS4=0, IF_ID_VALID=0, hold buffer and redirect register cleared, IMEM_READ=0.
REQ-030 RESET asserted mid-transaction (any state) SHALL abandon the access; first fetch after release is at RESET_PC.

Verification
REQ-031 Reset release, IMEM_BUSYWAIT=0, memory returns 0x00A00093,0x00100113,... -> IF_ID_PC = 0,4,8 on consecutive edges, IF_ID_VALID=1, IF_ID_PC_PLUS4 = 4,8,12.
REQ-032 IMEM_BUSYWAIT=1 for 3 cycles at PC=0x10 -> 3 bubbles (IF_ID_INSTR=0x00000013, VALID=0), then IF_ID_PC=0x10, VALID=1.
REQ-033 STALL=1 for 2 cycles while fetch of 0x20 completes -> IF/ID unchanged, IMEM_READ=0 in HELD; after STALL=0, IF_ID_PC=0x20 next edge, then fetch resumes at 0x24.
REQ-034 PC_SRC_SEL=1, BRANCH_TARGET=0x103 with IMEM_BUSYWAIT=0 -> IF/ID flushed same edge, next IMEM_ADDR=0x100; with STALL=1 simultaneously, result identical.
REQ-035 PC_SRC_SEL=1, target 0x200, during IMEM_BUSYWAIT=1 at PC=0x40 -> IMEM_ADDR stays 0x40 until busywait drops, data discarded (VALID=0), then IMEM_ADDR=0x200; second redirect to 0x300 during drain -> 0x300 fetched instead.
REQ-036 PC=0xFFFFFFFC, completion -> IF_ID_PC_PLUS4=0x00000000, next IMEM_ADDR=0x00000000; RESET pulsed mid-DRAIN -> all REQ-029 values immediately, first fetch at 0x00000000.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, one-entry hold
// buffer for stalls that land on a completed fetch, and redirect draining.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        PC_SRC_SEL,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] IMEM_INSTR,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] IF_ID_INSTR,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_PLUS4,
  output logic        IF_ID_VALID
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_pc4_reg, id_pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] redirect_reg, redirect_next;

  logic        fetch_done;
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;
  logic [31:0] drain_target;
  logic        unused_target_bits;

  assign fetch_done         = IMEM_READ && !IMEM_BUSYWAIT;
  assign target_aligned     = {BRANCH_TARGET[31:2], 2'b00};
  assign pc_plus4           = pc_reg + 32'd4;
  assign unused_target_bits = ^BRANCH_TARGET[1:0];
  // A redirect arriving during a drain replaces the one already saved.
  assign drain_target       = PC_SRC_SEL ? target_aligned : redirect_reg;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: begin
        if (PC_SRC_SEL) begin
          state_next = IMEM_BUSYWAIT ? DRAIN : FETCH;
        end else if (STALL && fetch_done) begin
          state_next = HELD;
        end
      end
      HELD: begin
        if (PC_SRC_SEL || !STALL) begin
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (fetch_done) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    IMEM_READ      = !RESET && (state_reg != HELD);
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    id_pc_next     = id_pc_reg;
    id_pc4_next    = id_pc4_reg;
    valid_next     = valid_reg;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    redirect_next  = redirect_reg;
    case (state_reg)
      FETCH: begin
        if (PC_SRC_SEL) begin
          instr_next     = NOP_INSTR;
          valid_next     = 1'b0;
          buf_instr_next = 32'd0;
          buf_pc_next    = 32'd0;
          if (IMEM_BUSYWAIT) begin
            redirect_next = target_aligned;
          end else begin
            pc_next = target_aligned;
          end
        end else if (STALL) begin
          if (fetch_done) begin
            buf_instr_next = IMEM_INSTR;
            buf_pc_next    = pc_reg;
            pc_next        = pc_plus4;
          end
        end else if (fetch_done) begin
          instr_next  = IMEM_INSTR;
          id_pc_next  = pc_reg;
          id_pc4_next = pc_plus4;
          valid_next  = 1'b1;
          pc_next     = pc_plus4;
        end else begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end
      end
      HELD: begin
        if (PC_SRC_SEL) begin
          pc_next        = target_aligned;
          instr_next     = NOP_INSTR;
          valid_next     = 1'b0;
          buf_instr_next = 32'd0;
          buf_pc_next    = 32'd0;
        end else if (!STALL) begin
          instr_next  = buf_instr_reg;
          id_pc_next  = buf_pc_reg;
          id_pc4_next = buf_pc_reg + 32'd4;
          valid_next  = 1'b1;
        end
      end
      DRAIN: begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
        if (fetch_done) begin
          pc_next = drain_target;
        end else begin
          redirect_next = drain_target;
        end
      end
      default: begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_reg        <= RESET_PC;
      instr_reg     <= NOP_INSTR;
      id_pc_reg     <= 32'd0;
      id_pc4_reg    <= 32'd0;
      valid_reg     <= 1'b0;
      buf_instr_reg <= 32'd0;
      buf_pc_reg    <= 32'd0;
      redirect_reg  <= 32'd0;
    end else begin
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      id_pc_reg     <= id_pc_next;
      id_pc4_reg    <= id_pc4_next;
      valid_reg     <= valid_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
      redirect_reg  <= redirect_next;
    end
  end

  assign IMEM_ADDR      = pc_reg;
  assign IF_ID_INSTR    = instr_reg;
  assign IF_ID_PC       = id_pc_reg;
  assign IF_ID_PC_PLUS4 = id_pc4_reg;
  assign IF_ID_VALID    = valid_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        PC_SRC_SEL;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_INSTR;
  logic        IMEM_BUSYWAIT;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IF_ID_INSTR;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PC_PLUS4;
  logic        IF_ID_VALID;

  int tests = 0;
  int fails = 0;

  instruction_fetch_unit dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .STALL          (STALL),
    .PC_SRC_SEL     (PC_SRC_SEL),
    .BRANCH_TARGET  (BRANCH_TARGET),
    .IMEM_INSTR     (IMEM_INSTR),
    .IMEM_BUSYWAIT  (IMEM_BUSYWAIT),
    .IMEM_READ      (IMEM_READ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IF_ID_INSTR    (IF_ID_INSTR),
    .IF_ID_PC       (IF_ID_PC),
    .IF_ID_PC_PLUS4 (IF_ID_PC_PLUS4),
    .IF_ID_VALID    (IF_ID_VALID)
  );

  always #5 CLK = ~CLK;

  // Reference model: PC, IF/ID contents, an optional held instruction and an
  // optional pending redirect target.
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_redir, m_buf_instr, m_buf_pc;
  logic        m_valid, m_held, m_drain, m_in_reset;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic m_read;
    m_read = !m_in_reset && !m_held;
    check({tag, ".instr"}, IF_ID_INSTR, m_instr);
    check({tag, ".pc"}, IF_ID_PC, m_idpc);
    check({tag, ".pc4"}, IF_ID_PC_PLUS4, m_idpc4);
    check({tag, ".valid"}, {31'd0, IF_ID_VALID}, {31'd0, m_valid});
    check({tag, ".addr"}, IMEM_ADDR, m_pc);
    check({tag, ".read"}, {31'd0, IMEM_READ}, {31'd0, m_read});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_idpc = 32'h0; m_idpc4 = 32'h0; m_valid = 1'b0;
    m_held = 1'b0; m_drain = 1'b0; m_redir = 32'h0; m_buf_instr = 32'h0; m_buf_pc = 32'h0;
  endtask

  task automatic model_edge(input bit stall, input bit pcs, input logic [31:0] tgt,
                            input bit busy, input logic [31:0] instr);
    logic [31:0] tgt_a;
    bit done;
    tgt_a = tgt & 32'hFFFF_FFFC;
    done  = !m_held && !busy;
    if (m_drain) begin
      m_instr = NOP; m_valid = 1'b0;
      if (pcs) m_redir = tgt_a;
      if (done) begin m_pc = m_redir; m_drain = 1'b0; end
    end else if (pcs) begin
      m_instr = NOP; m_valid = 1'b0;
      if (m_held || !busy) m_pc = tgt_a;
      else begin m_redir = tgt_a; m_drain = 1'b1; end
      m_held = 1'b0;
    end else if (m_held) begin
      if (!stall) begin
        m_instr = m_buf_instr; m_idpc = m_buf_pc; m_idpc4 = m_buf_pc + 32'd4;
        m_valid = 1'b1; m_held = 1'b0;
      end
    end else if (stall) begin
      if (done) begin
        m_buf_instr = instr; m_buf_pc = m_pc; m_pc = m_pc + 32'd4; m_held = 1'b1;
      end
    end else if (done) begin
      m_instr = instr; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_instr = NOP; m_valid = 1'b0;
    end
  endtask

  // Called 1 time unit after a rising edge; drives inputs, clocks once, checks.
  task automatic step(input string tag, input bit stall, input bit pcs,
                      input logic [31:0] tgt, input bit busy);
    STALL = stall; PC_SRC_SEL = pcs; BRANCH_TARGET = tgt; IMEM_BUSYWAIT = busy;
    IMEM_INSTR = mem_word(IMEM_ADDR);
    model_edge(stall, pcs, tgt, busy, IMEM_INSTR);
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; PC_SRC_SEL = 1'b0; BRANCH_TARGET = 32'h0;
    IMEM_BUSYWAIT = 1'b0; IMEM_INSTR = 32'h0;
    m_in_reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(posedge CLK); #1;
    RESET = 1'b0; m_in_reset = 1'b0;
    #1;
    check_all("release");

    // Zero-wait sequential fetch
    step("seq0", 0, 0, 0, 0);
    check("seq0.word", IF_ID_INSTR, 32'h00A0_0093);
    check("seq0.pc4", IF_ID_PC_PLUS4, 32'h4);
    step("seq1", 0, 0, 0, 0);
    check("seq1.word", IF_ID_INSTR, 32'h0010_0113);
    step("seq2", 0, 0, 0, 0);
    check("seq2.pc4", IF_ID_PC_PLUS4, 32'hC);
    step("seq3", 0, 0, 0, 0);
    check("busy.addr", IMEM_ADDR, 32'h10);

    // Busywait at 0x10
    for (int i = 0; i < 3; i++) begin
      step("busy", 0, 0, 0, 1);
      check("busy.bubble", IF_ID_INSTR, NOP);
    end
    step("busy_done", 0, 0, 0, 0);
    check("busy_done.pc", IF_ID_PC, 32'h10);

    // Stall while fetch of 0x20 completes
    for (int i = 0; i < 3; i++) step("to20", 0, 0, 0, 0);
    check("stall.addr", IMEM_ADDR, 32'h20);
    step("stall0", 1, 0, 0, 0);
    check("stall0.read", {31'd0, IMEM_READ}, 32'd0);
    step("stall1", 1, 0, 0, 0);
    step("unstall", 0, 0, 0, 0);
    check("unstall.pc", IF_ID_PC, 32'h20);
    step("resume", 0, 0, 0, 0);
    check("resume.pc", IF_ID_PC, 32'h24);

    // Redirect with memory ready, plain and under stall
    step("br", 0, 1, 32'h103, 0);
    check("br.addr", IMEM_ADDR, 32'h100);
    step("br_seq", 0, 0, 0, 0);
    step("br_stall", 1, 1, 32'h103, 0);
    check("br_stall.addr", IMEM_ADDR, 32'h100);

    // Redirect during busywait, then drain
    step("to40", 0, 1, 32'h40, 0);
    step("drain_in", 0, 1, 32'h200, 1);
    step("drain_w", 0, 0, 0, 1);
    check("drain_w.addr", IMEM_ADDR, 32'h40);
    step("drain_out", 0, 0, 0, 0);
    check("drain_out.addr", IMEM_ADDR, 32'h200);
    step("to40b", 0, 1, 32'h40, 0);
    step("drain2_in", 0, 1, 32'h200, 1);
    step("drain2_re", 0, 1, 32'h300, 1);
    step("drain2_out", 0, 0, 0, 0);
    check("drain2_out.addr", IMEM_ADDR, 32'h300);

    // PC wrap
    step("towrap", 0, 1, 32'hFFFF_FFFC, 0);
    step("wrap", 0, 0, 0, 0);
    check("wrap.pc4", IF_ID_PC_PLUS4, 32'h0);
    check("wrap.addr", IMEM_ADDR, 32'h0);

    // Reset mid-drain
    step("rst40", 0, 1, 32'h40, 0);
    step("rst_drain", 0, 1, 32'h200, 1);
    #2;
    RESET = 1'b1; m_in_reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_mid");
    @(posedge CLK); #1;
    RESET = 1'b0; m_in_reset = 1'b0;
    step("rst_first", 0, 0, 0, 0);
    check("rst_first.pc", IF_ID_PC, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit r_stall, r_pcs, r_busy;
      logic [31:0] r_tgt;
      r_stall = ($urandom_range(0, 2) == 0);
      r_pcs   = ($urandom_range(0, 7) == 0);
      r_busy  = ($urandom_range(0, 2) == 0);
      r_tgt   = $urandom;
      step("rand", r_stall, r_pcs, r_tgt, r_busy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
